// File: rtl/commit_pkg.sv
// Shared types and width constants for the commit trace path.
package commit_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  // One captured retirement: 224 bits total.
  typedef struct packed {
    logic [XLEN-1:0] pre_pc;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] seq;
  } commit_entry_t;

endpackage

// File: rtl/commit_fifo.sv
// Show-ahead FIFO of commit_entry_t. The head entry is always presented on
// rdata. A push into a full FIFO is accepted only when a pop happens in the
// same cycle. Storage is not reset; only pointers and occupancy are.
module commit_fifo
  import commit_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  commit_entry_t wdata,
  input  logic          pop,
  output commit_entry_t rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  commit_entry_t mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count_next;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rptr];

  // Occupancy update from the accepted push/pop pair.
  always_comb begin
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  // Storage write; data path carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

  // Pointer and occupancy registers; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      count <= count_next;
    end
  end

endmodule

// File: rtl/commit_trace_buf.sv
// Commit trace endpoint: captures retiring instructions into a FIFO, tags
// them with a retirement sequence number and drains them over valid/ready.
// Optional PC continuity checker enabled by defining COMMIT_CHECK_EN.
module commit_trace_buf
  import commit_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            regW_i_commit,
  input  logic [XLEN-1:0] regW_i_commit_pre_pc,
  input  logic [ILEN-1:0] regW_i_commit_instr,
  input  logic [XLEN-1:0] regW_i_commit_pc,
  output logic            trace_o_valid,
  input  logic            trace_i_ready,
  output logic [XLEN-1:0] trace_o_pre_pc,
  output logic [ILEN-1:0] trace_o_instr,
  output logic [XLEN-1:0] trace_o_pc,
  output logic [XLEN-1:0] trace_o_seq,
  output logic            trace_o_stall_req,
  output logic [XLEN-1:0] trace_o_instret,
  output logic            trace_o_overflow,
  output logic            trace_o_pc_err,
  output logic [XLEN-1:0] trace_o_err_pc
);

  localparam int AW = $clog2(DEPTH);

  commit_entry_t wdata;
  commit_entry_t head;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          pop;
  logic          dropped;

  assign wdata = '{pre_pc: regW_i_commit_pre_pc,
                   instr:  regW_i_commit_instr,
                   pc:     regW_i_commit_pc,
                   seq:    trace_o_instret};

  assign trace_o_valid = !empty;
  assign pop           = trace_o_valid && trace_i_ready;
  assign dropped       = regW_i_commit && full && !pop;

  commit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (regW_i_commit),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Head fields read zero while empty so unreset storage never shows through.
  assign trace_o_pre_pc = empty ? '0 : head.pre_pc;
  assign trace_o_instr  = empty ? '0 : head.instr;
  assign trace_o_pc     = empty ? '0 : head.pc;
  assign trace_o_seq    = empty ? '0 : head.seq;

  // Retired count (dropped commits included), sticky overflow, and stall
  // request lagging the registered occupancy by one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trace_o_instret   <= '0;
      trace_o_overflow  <= 1'b0;
      trace_o_stall_req <= 1'b0;
    end else begin
      if (regW_i_commit) trace_o_instret <= trace_o_instret + XLEN'(1);
      if (dropped)       trace_o_overflow <= 1'b1;
      trace_o_stall_req <= (count >= (AW+1)'(DEPTH - AF_MARGIN));
    end
  end

`ifdef COMMIT_CHECK_EN
  logic [XLEN-1:0] last_pc;
  logic            have_last;

  // Continuity check: each commit must start where the previous one ended.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      have_last      <= 1'b0;
      trace_o_pc_err <= 1'b0;
      trace_o_err_pc <= '0;
    end else if (regW_i_commit) begin
      have_last <= 1'b1;
      if (have_last && (regW_i_commit_pre_pc != last_pc)) begin
        trace_o_pc_err <= 1'b1;
        if (!trace_o_pc_err) trace_o_err_pc <= regW_i_commit_pre_pc;
      end
    end
  end

  // Expected start PC of the next commit; qualified by have_last.
  always_ff @(posedge clk) begin
    if (regW_i_commit) last_pc <= regW_i_commit_pc;
  end
`else
  assign trace_o_pc_err = 1'b0;
  assign trace_o_err_pc = '0;
`endif

endmodule

// File: tb/tb_commit_trace_buf.sv
// Testbench for commit_trace_buf: directed scenarios plus random traffic,
// scoreboard of expected head entries checked by an independent monitor.
module tb_commit_trace_buf;

  localparam int DEPTH = 8;
  localparam int AF    = 2;

  logic        clk;
  logic        rst_n;
  logic        regW_i_commit;
  logic [63:0] regW_i_commit_pre_pc;
  logic [31:0] regW_i_commit_instr;
  logic [63:0] regW_i_commit_pc;
  logic        trace_o_valid;
  logic        trace_i_ready;
  logic [63:0] trace_o_pre_pc;
  logic [31:0] trace_o_instr;
  logic [63:0] trace_o_pc;
  logic [63:0] trace_o_seq;
  logic        trace_o_stall_req;
  logic [63:0] trace_o_instret;
  logic        trace_o_overflow;
  logic        trace_o_pc_err;
  logic [63:0] trace_o_err_pc;

  commit_trace_buf #(.DEPTH(DEPTH), .AF_MARGIN(AF)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .regW_i_commit        (regW_i_commit),
    .regW_i_commit_pre_pc (regW_i_commit_pre_pc),
    .regW_i_commit_instr  (regW_i_commit_instr),
    .regW_i_commit_pc     (regW_i_commit_pc),
    .trace_o_valid        (trace_o_valid),
    .trace_i_ready        (trace_i_ready),
    .trace_o_pre_pc       (trace_o_pre_pc),
    .trace_o_instr        (trace_o_instr),
    .trace_o_pc           (trace_o_pc),
    .trace_o_seq          (trace_o_seq),
    .trace_o_stall_req    (trace_o_stall_req),
    .trace_o_instret      (trace_o_instret),
    .trace_o_overflow     (trace_o_overflow),
    .trace_o_pc_err       (trace_o_pc_err),
    .trace_o_err_pc       (trace_o_err_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pre_pc;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] seq;
  } exp_t;

  exp_t expq[$];
  exp_t e;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          occ_m   = 0;
  int          occ_pre = 0;
  logic [63:0] instret_m = '0;
  bit          ovf_m = 0;
  bit          stall_m = 0;
  bit          pcerr_m = 0;
  bit          have_last_m = 0;
  logic [63:0] err_pc_m = '0;
  logic [63:0] last_pc_m = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model over the coming edge,
  // then check the architectural outputs just after that edge.
  task automatic step(input bit c, input logic [63:0] pre, input logic [31:0] ins,
                      input logic [63:0] npc, input bit rdy, input bit rn);
    bit pop;
    bit acc;
    rst_n                = rn;
    regW_i_commit        = c;
    regW_i_commit_pre_pc = pre;
    regW_i_commit_instr  = ins;
    regW_i_commit_pc     = npc;
    trace_i_ready        = rdy;
    occ_pre = occ_m;
    if (!rn) begin
      occ_m = 0; expq.delete(); instret_m = '0; ovf_m = 0; stall_m = 0;
      pcerr_m = 0; err_pc_m = '0; have_last_m = 0;
    end else begin
      pop = (occ_m > 0) && rdy;
      acc = c && ((occ_m < DEPTH) || pop);
      stall_m = (occ_m >= DEPTH - AF);
      if (acc) expq.push_back('{pre, ins, npc, instret_m});
      if (c && !acc) ovf_m = 1;
`ifdef COMMIT_CHECK_EN
      if (c) begin
        if (have_last_m && pre != last_pc_m) begin
          if (!pcerr_m) err_pc_m = pre;
          pcerr_m = 1;
        end
        last_pc_m = npc;
        have_last_m = 1;
      end
`endif
      if (c) instret_m = instret_m + 64'd1;
      occ_m = occ_m + int'(acc) - int'(pop);
    end
    @(posedge clk); #1;
    chk("instret", trace_o_instret, instret_m);
    chk("overflow", trace_o_overflow, ovf_m);
    chk("stall_req", trace_o_stall_req, stall_m);
    chk("pc_err", trace_o_pc_err, pcerr_m);
    chk("err_pc", trace_o_err_pc, err_pc_m);
  endtask

  task automatic commit(input logic [63:0] pre, input logic [31:0] ins,
                        input logic [63:0] npc, input bit rdy);
    step(1'b1, pre, ins, npc, rdy, 1'b1);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, '0, '0, '0, rdy, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  // Monitor: head must match the oldest expected entry; a handshake retires it.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("valid", trace_o_valid, occ_pre > 0);
      if (trace_o_valid) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL head_unexpected: got seq %h expected no entry", trace_o_seq);
        end else begin
          e = expq[0];
          chk("head_pre_pc", trace_o_pre_pc, e.pre_pc);
          chk("head_instr", trace_o_instr, e.instr);
          chk("head_pc", trace_o_pc, e.pc);
          chk("head_seq", trace_o_seq, e.seq);
          if (trace_i_ready) void'(expq.pop_front());
        end
      end
    end
  end

  logic [63:0] rpc;
  logic [63:0] rnpc;

  initial begin
    rst_n = 0; regW_i_commit = 0; regW_i_commit_pre_pc = '0;
    regW_i_commit_instr = '0; regW_i_commit_pc = '0; trace_i_ready = 0;
    do_reset(); do_reset();
    chk("rst_valid", trace_o_valid, 0);
    chk("rst_pre_pc", trace_o_pre_pc, 0);
    chk("rst_instr", trace_o_instr, 0);
    chk("rst_pc", trace_o_pc, 0);
    chk("rst_seq", trace_o_seq, 0);

    // Single commit
    commit(64'h8000_0000, 32'h0000_0013, 64'h8000_0004, 1'b0);
    chk("single_valid", trace_o_valid, 1);
    chk("single_seq", trace_o_seq, 0);
    chk("single_pre_pc", trace_o_pre_pc, 64'h8000_0000);
    chk("single_instr", trace_o_instr, 32'h13);
    chk("single_pc", trace_o_pc, 64'h8000_0004);
    idle(1'b1);
    chk("single_valid_after_pop", trace_o_valid, 0);
    chk("single_instret", trace_o_instret, 1);
    idle(1'b0);

    // Burst of 9 into a full FIFO
    do_reset();
    for (int i = 0; i < 9; i++)
      commit(64'h8000_1000 + 64'(4*i), $urandom, 64'h8000_1004 + 64'(4*i), 1'b0);
    chk("burst_overflow", trace_o_overflow, 1);
    chk("burst_instret", trace_o_instret, 9);
    for (int i = 0; i < 8; i++) idle(1'b1);
    idle(1'b0);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++)
      commit(64'h100 + 64'(4*i), $urandom, 64'h104 + 64'(4*i), 1'b0);
    for (int i = 8; i < 28; i++)
      commit(64'h100 + 64'(4*i), $urandom, 64'h104 + 64'(4*i), 1'b1);
    chk("fullpp_overflow", trace_o_overflow, 0);
    chk("fullpp_valid", trace_o_valid, 1);
    for (int i = 0; i < 8; i++) idle(1'b1);
    idle(1'b0);

    // Stall request timing
    do_reset();
    for (int i = 0; i < 6; i++)
      commit(64'h200 + 64'(4*i), $urandom, 64'h204 + 64'(4*i), 1'b0);
    chk("stall_lag", trace_o_stall_req, 0);
    idle(1'b0);
    chk("stall_set", trace_o_stall_req, 1);
    idle(1'b1);
    chk("stall_hold", trace_o_stall_req, 1);
    idle(1'b0);
    chk("stall_clear", trace_o_stall_req, 0);
    for (int i = 0; i < 5; i++) idle(1'b1);

`ifdef COMMIT_CHECK_EN
    // Continuity checker
    do_reset();
    commit(64'h8000_0000, 32'h13, 64'h8000_0004, 1'b1);
    commit(64'h8000_0004, 32'h13, 64'h8000_0008, 1'b1);
    chk("chk_no_err", trace_o_pc_err, 0);
    commit(64'h8000_0100, 32'h13, 64'h8000_0104, 1'b1);
    chk("chk_err", trace_o_pc_err, 1);
    chk("chk_err_pc", trace_o_err_pc, 64'h8000_0100);
    commit(64'h9000_0000, 32'h13, 64'h9000_0004, 1'b1);
    chk("chk_err_pc_kept", trace_o_err_pc, 64'h8000_0100);
    idle(1'b1); idle(1'b1);
`endif

    // Reset mid-burst
    do_reset();
    for (int i = 0; i < 5; i++)
      commit(64'h300 + 64'(4*i), $urandom, 64'h304 + 64'(4*i), 1'b0);
    do_reset();
    chk("midrst_valid", trace_o_valid, 0);
    chk("midrst_instret", trace_o_instret, 0);
    chk("midrst_overflow", trace_o_overflow, 0);
    chk("midrst_pc_err", trace_o_pc_err, 0);
    commit(64'h400, 32'h13, 64'h404, 1'b0);
    chk("midrst_seq0", trace_o_seq, 0);
    idle(1'b1);

    // Random traffic
    do_reset();
    rpc = 64'h8000_0000;
    for (int i = 0; i < 800; i++) begin
      bit c;
      bit rdy;
      int rmode;
      rmode = (i / 200) % 4;
      c   = ($urandom_range(0, 99) < 65);
      rdy = ($urandom_range(0, 99) < (rmode == 0 ? 80 : rmode == 1 ? 20 : 50));
      if ($urandom_range(0, 99) < 5) rpc = {$urandom, $urandom};
      rnpc = ($urandom_range(0, 9) == 0) ? {32'h0, $urandom} : rpc + 64'd4;
      if ($urandom_range(0, 299) == 0) do_reset();
      else if (c) begin
        commit(rpc, $urandom, rnpc, rdy);
        rpc = rnpc;
      end else idle(rdy);
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    chk("final_queue_empty", 64'(expq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
